// File: rtl/i2c_cmd_arbiter.sv
// Arbiter sharing one I2C/SCCB driver between the init sequencer (port 0) and a runtime
// command port (port 1). Optional single retry on timeout via macro I2C_ARB_RETRY_EN.
module i2c_cmd_arbiter #(
  parameter int TIMEOUT_CYC = 2047,
  parameter int GAP_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_exec,
  input  logic [15:0] c0_data,
  output logic        c0_done,
  input  logic        c0_busy,
  input  logic        c1_valid,
  output logic        c1_ready,
  input  logic        c1_rh_wl,
  input  logic [15:0] c1_data,
  output logic        c1_done,
  output logic [7:0]  c1_rdata,
  output logic        c1_err,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_data,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_data_r,
  output logic [7:0]  timeout_cnt
);

  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t          state;
  state_t          state_next;
  logic            pend0;
  logic [15:0]     pend_data;
  logic            owner;
  logic            err;
  logic [7:0]      rdata;
  logic [WW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      to_cnt;
  logic [15:0]     data_q;
  logic            rh_wl_q;
  logic            pend_any;
  logic            start;
  logic            timed_out;
  logic            last_try;
  logic [WW-1:0]   wait_lim;

`ifdef I2C_ARB_RETRY_EN
  logic retry;
  // The retry window is one cycle longer so a double abort lands at 2*TIMEOUT_CYC+1.
  assign last_try = retry;
  assign wait_lim = retry ? WW'(TIMEOUT_CYC) : WW'(TIMEOUT_CYC - 1);
`else
  assign last_try = 1'b1;
  assign wait_lim = WW'(TIMEOUT_CYC - 1);
`endif

  // A fresh c0_exec counts as pending in the same cycle so port 0 beats a coincident port 1.
  assign pend_any  = pend0 | c0_exec;
  assign start     = (state == IDLE) && (gap_cnt == '0) && (pend_any || (c1_valid && c1_ready));
  assign timed_out = (state == WAIT) && !i2c_done && (wait_cnt == wait_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (i2c_done)       state_next = DONE;
        else if (timed_out) state_next = last_try ? DONE : ISSUE;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    c1_ready = (state == IDLE) && !pend_any && !c0_busy && (gap_cnt == '0);
    i2c_exec = (state == ISSUE);
    c0_done  = (state == DONE) && !owner;
    c1_done  = (state == DONE) && owner;
    c1_err   = c1_done && err;
    c1_rdata = c1_done ? rdata : 8'h00;
  end

  assign i2c_data    = data_q;
  assign i2c_rh_wl   = rh_wl_q;
  assign timeout_cnt = to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0     <= 1'b0;
      pend_data <= '0;
    end else if (state == ISSUE && !owner) begin
      pend0 <= 1'b0;
    end else if (c0_exec && !pend0) begin
      pend0     <= 1'b1;
      pend_data <= c0_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= 1'b0;
      data_q  <= '0;
      rh_wl_q <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      to_cnt  <= '0;
    end else begin
      if (start) begin
        owner <= !pend_any;
        err   <= 1'b0;
        rdata <= '0;
        if (pend_any) begin
          data_q  <= pend0 ? pend_data : c0_data;
          rh_wl_q <= 1'b0;
        end else begin
          data_q  <= c1_data;
          rh_wl_q <= c1_rh_wl;
        end
      end
      if (state == WAIT && i2c_done) begin
        rdata <= i2c_data_r;
        err   <= 1'b0;
      end else if (timed_out && last_try) begin
        err <= 1'b1;
        if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
      end
    end
  end

  // wait_cnt equals the number of cycles since the ISSUE cycle of the current attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state_next == ISSUE)                    wait_cnt <= '0;
      else if (state == ISSUE || state == WAIT)   wait_cnt <= wait_cnt + 1'b1;

      if (state_next == DONE)  gap_cnt <= GW'(GAP_CYC);
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef I2C_ARB_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     retry <= 1'b0;
    else if (start)                 retry <= 1'b0;
    else if (timed_out && !retry)   retry <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: priority, gap, read path, timeout, port-0 lockout, reset.
module tb_i2c_cmd_arbiter;
  localparam int TIMEOUT_CYC = 2047;
  localparam int GAP_CYC     = 4;

  logic        clk;
  logic        rst_n;
  logic        c0_exec;
  logic [15:0] c0_data;
  logic        c0_done;
  logic        c0_busy;
  logic        c1_valid;
  logic        c1_ready;
  logic        c1_rh_wl;
  logic [15:0] c1_data;
  logic        c1_done;
  logic [7:0]  c1_rdata;
  logic        c1_err;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_data;
  logic        i2c_done;
  logic [7:0]  i2c_data_r;
  logic [7:0]  timeout_cnt;

  i2c_cmd_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_exec(c0_exec), .c0_data(c0_data), .c0_done(c0_done), .c0_busy(c0_busy),
    .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_rh_wl(c1_rh_wl), .c1_data(c1_data),
    .c1_done(c1_done), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_data(i2c_data),
    .i2c_done(i2c_done), .i2c_data_r(i2c_data_r), .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;
  int   n;
  int   ready_hi = 0;
  int   done_cnt = 0;
  int   late = 0;
  int   exp_to;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the falling edge; outputs are read there too.
  task automatic tick();
    @(negedge clk);
    if (mon_en && c1_ready) ready_hi++;
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return i2c_exec;
      1:       return c0_done;
      2:       return c1_done;
      3:       return c1_ready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int max, output int cnt);
    cnt = 0;
    #1;
    while (!sig(sel) && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; c0_exec = 1'b0; c0_data = '0; c0_busy = 1'b1;
    c1_valid = 1'b0; c1_rh_wl = 1'b0; c1_data = '0; i2c_done = 1'b0; i2c_data_r = '0;
`ifdef I2C_ARB_RETRY_EN
    exp_to = 2 * TIMEOUT_CYC + 1;
`else
    exp_to = TIMEOUT_CYC;
`endif
    tick(); tick();
    check("rst_exec",    32'(i2c_exec), 32'd0);
    check("rst_c0_done", 32'(c0_done), 32'd0);
    check("rst_c1_done", 32'(c1_done), 32'd0);
    check("rst_c1_rdy",  32'(c1_ready), 32'd0);
    check("rst_data",    32'(i2c_data), 32'd0);
    check("rst_to_cnt",  32'(timeout_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Port 0 write
    c0_exec = 1'b1; c0_data = 16'h1280;
    tick(); c0_exec = 1'b0;
    check("t1_exec", 32'(i2c_exec), 32'd1);
    check("t1_data", 32'(i2c_data), 32'h1280);
    check("t1_rh",   32'(i2c_rh_wl), 32'd0);
    tick();
    check("t1_exec_once", 32'(i2c_exec), 32'd0);
    i2c_done = 1'b1;
    tick(); i2c_done = 1'b0;
    check("t1_c0_done", 32'(c0_done), 32'd1);
    check("t1_c1_done", 32'(c1_done), 32'd0);
    check("t1_hold",    32'(i2c_data), 32'h1280);
    tick();
    check("t1_done_once", 32'(c0_done), 32'd0);

    // Port 1 read
    c0_busy = 1'b0;
    repeat (5) tick();
    c1_valid = 1'b1; c1_rh_wl = 1'b1; c1_data = 16'h1C55;
    #1 check("t2_ready", 32'(c1_ready), 32'd1);
    tick(); c1_valid = 1'b0;
    check("t2_exec", 32'(i2c_exec), 32'd1);
    check("t2_rh",   32'(i2c_rh_wl), 32'd1);
    check("t2_data", 32'(i2c_data), 32'h1C55);
    check("t2_ready_busy", 32'(c1_ready), 32'd0);
    tick(); i2c_done = 1'b1; i2c_data_r = 8'h7F;
    tick(); i2c_done = 1'b0; i2c_data_r = 8'h00;
    check("t2_c1_done", 32'(c1_done), 32'd1);
    check("t2_rdata",   32'(c1_rdata), 32'h7F);
    check("t2_err",     32'(c1_err), 32'd0);
    check("t2_c0_done", 32'(c0_done), 32'd0);

    // Same-cycle collision: port 0 first, port 1 after the gap
    repeat (5) tick();
    c0_exec = 1'b1; c0_data = 16'hABCD;
    c1_valid = 1'b1; c1_rh_wl = 1'b0; c1_data = 16'h3344;
    #1 check("t3_ready_blocked", 32'(c1_ready), 32'd0);
    tick(); c0_exec = 1'b0;
    check("t3_exec0", 32'(i2c_exec), 32'd1);
    check("t3_data0", 32'(i2c_data), 32'hABCD);
    tick(); i2c_done = 1'b1;
    tick(); i2c_done = 1'b0;
    check("t3_c0_done", 32'(c0_done), 32'd1);
    wait_sig(0, 50, n);
    c1_valid = 1'b0;
    check("t3_gap",   32'(n), 32'(GAP_CYC + 1));
    check("t3_data1", 32'(i2c_data), 32'h3344);
    check("t3_rh1",   32'(i2c_rh_wl), 32'd0);

    // No i2c_done for the port 1 write: watchdog abort
    wait_sig(2, 5000, n);
    check("t4_latency", 32'(n), 32'(exp_to));
    check("t4_err",     32'(c1_err), 32'd1);
    check("t4_to_cnt",  32'(timeout_cnt), 32'd1);
    check("t4_c0_done", 32'(c0_done), 32'd0);
    tick();
    check("t4_err_clr", 32'(c1_err), 32'd0);

    // Port 1 locked out while the sequencer is busy
    c0_busy = 1'b1; c1_valid = 1'b1; c1_rh_wl = 1'b0; c1_data = 16'h5566;
    mon_en = 1'b1;
    for (int i = 0; i < 70; i++) begin
      c0_exec = 1'b1; c0_data = 16'(i);
      tick(); c0_exec = 1'b0;
      wait_sig(0, 20, n);
      if (n == 20) late++;
      tick(); i2c_done = 1'b1;
      tick(); i2c_done = 1'b0;
      if (c0_done) done_cnt++;
    end
    mon_en = 1'b0;
    check("t5_ready_low", 32'(ready_hi), 32'd0);
    check("t5_done_cnt",  32'(done_cnt), 32'd70);
    check("t5_late",      32'(late), 32'd0);
    c0_busy = 1'b0;
    wait_sig(3, 10, n);
    check("t5_ready_up", 32'(c1_ready), 32'd1);
    tick(); c1_valid = 1'b0;
    check("t5_exec", 32'(i2c_exec), 32'd1);
    check("t5_data", 32'(i2c_data), 32'h5566);
    tick(); i2c_done = 1'b1;
    tick(); i2c_done = 1'b0;
    check("t5_c1_done", 32'(c1_done), 32'd1);
    check("t5_c1_err",  32'(c1_err), 32'd0);

    // Reset while waiting on the driver
    repeat (5) tick();
    c0_busy = 1'b1;
    c0_exec = 1'b1; c0_data = 16'h0A0B;
    tick(); c0_exec = 1'b0;
    check("t6_exec", 32'(i2c_exec), 32'd1);
    tick();
    rst_n = 1'b0; i2c_done = 1'b1;
    tick();
    check("t6_rst_exec",   32'(i2c_exec), 32'd0);
    check("t6_rst_c0",     32'(c0_done), 32'd0);
    check("t6_rst_c1",     32'(c1_done), 32'd0);
    check("t6_rst_ready",  32'(c1_ready), 32'd0);
    check("t6_rst_data",   32'(i2c_data), 32'd0);
    check("t6_rst_to_cnt", 32'(timeout_cnt), 32'd0);
    tick(); rst_n = 1'b1; i2c_done = 1'b0;
    tick();
    check("t6_no_done", 32'(c0_done), 32'd0);
    i2c_done = 1'b1;
    tick(); i2c_done = 1'b0;
    check("t6_stray_c0", 32'(c0_done), 32'd0);
    check("t6_stray_c1", 32'(c1_done), 32'd0);
    c0_exec = 1'b1; c0_data = 16'h1234;
    tick(); c0_exec = 1'b0;
    check("t6_exec2", 32'(i2c_exec), 32'd1);
    check("t6_data2", 32'(i2c_data), 32'h1234);
    tick(); i2c_done = 1'b1;
    tick(); i2c_done = 1'b0;
    check("t6_c0_done", 32'(c0_done), 32'd1);
    check("t6_c1_done", 32'(c1_done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
